// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with valid/ready byte input; define UART_TX_PARITY_EN to add a parity bit
module uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_o,
   output logic       tx_busy_o,
   output logic       tx_done_o
);
   localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
   localparam int BW = (BAUD_TICK < 2) ? 1 : $clog2(BAUD_TICK);
   if (STOP_BITS < 1 || STOP_BITS > 2 || BAUD_TICK < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx: STOP_BITS must be 1 or 2, BAUD_TICK >= 2, PARITY_ODD 0 or 1");
   end
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t         state, state_nxt;
   logic [BW-1:0]  baud_cnt, baud_nxt;
   logic [2:0]     bit_cnt, bit_nxt;
   logic [7:0]     shift, shift_nxt;
   logic           tx_nxt, done_nxt, bit_end;
`ifdef UART_TX_PARITY_EN
   logic           par, par_nxt;
`endif
   assign tx_ready_o = (state == IDLE);
   assign tx_busy_o  = !tx_ready_o;
   assign bit_end    = (baud_cnt == BW'(BAUD_TICK - 1));
   // next-state, counters and the registered line value for the following cycle
   always_comb begin
      state_nxt = state;
      baud_nxt  = (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par;
`endif
      case (state)
         IDLE: if (tx_valid_i) begin
            state_nxt = START;
            bit_nxt   = '0;
            shift_nxt = tx_data_i;
`ifdef UART_TX_PARITY_EN
            par_nxt   = ^tx_data_i ^ PARITY_ODD[0];
`endif
         end
         START: if (bit_end) state_nxt = DATA;
         DATA: if (bit_end) begin
            shift_nxt = shift >> 1;
            bit_nxt   = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
            if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_nxt = STOP;
`endif
         STOP: if (bit_end) begin
            bit_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'(STOP_BITS - 1)) begin
               state_nxt = IDLE;
               bit_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
`ifdef UART_TX_PARITY_EN
      tx_nxt = (state_nxt == START) ? 1'b0 : (state_nxt == DATA) ? shift_nxt[0] : (state_nxt == PARITY) ? par_nxt : 1'b1;
`else
      tx_nxt = (state_nxt == START) ? 1'b0 : (state_nxt == DATA) ? shift_nxt[0] : 1'b1;
`endif
   end
   // state and datapath registers; reset aborts any frame and forces the line idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         tx_o      <= 1'b1;
         tx_done_o <= 1'b0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_nxt;
         bit_cnt   <= bit_nxt;
         shift     <= shift_nxt;
         tx_o      <= tx_nxt;
         tx_done_o <= done_nxt;
      end
   end
`ifdef UART_TX_PARITY_EN
   // parity of the accepted byte, held for the parity bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par <= 1'b0;
      else        par <= par_nxt;
   end
`endif
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks on a 1-stop and a 2-stop uart_tx at BAUD_TICK=10
module tb_uart_tx;
   localparam int BT = 10;
   localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] valid = '0;
   logic [7:0] data [2];
   logic [1:0] ready, tx, busy, done;
   int         vecs = 0;
   int         errs = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(1), .PARITY_ODD(PO)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
      .tx_ready_o(ready[0]), .tx_o(tx[0]), .tx_busy_o(busy[0]), .tx_done_o(done[0]));

   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .STOP_BITS(2), .PARITY_ODD(PO)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
      .tx_ready_o(ready[1]), .tx_o(tx[1]), .tx_busy_o(busy[1]), .tx_done_o(done[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // d selects the DUT; pre means the byte was already accepted by a held valid;
   // hold keeps valid high with nxt queued; poke pulses a second request mid-frame
   task automatic send(input int d, input logic [7:0] b, input bit pre, input bit hold,
                       input logic [7:0] nxt, input bit poke);
      logic exp_bits [0:11];
      int   nb;
      nb = 9 + PB + (d == 1 ? 2 : 1);
      for (int k = 0; k < 12; k++) exp_bits[k] = 1'b1;
      exp_bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
      if (PB == 1) exp_bits[9] = ^b ^ PO[0];
      if (!pre) begin
         check("ready_before", {31'd0, ready[d]}, 32'd1);
         data[d]  = b;
         valid[d] = 1'b1;
      end
      @(posedge clk); #1;
      valid[d] = hold;
      data[d]  = hold ? nxt : ~b;
      for (int i = 0; i < nb; i++) begin
         for (int c = 0; c < BT; c++) begin
            check("tx_bit", {31'd0, tx[d]}, {31'd0, exp_bits[i]});
            if (c == 0) check("busy", {30'd0, busy[d], ready[d]}, 32'd2);
            if (c == BT - 1) check("done_early", {31'd0, done[d]}, 32'd0);
            if (poke && i == 4 && c == 0) begin
               data[d]  = 8'h5A;
               valid[d] = 1'b1;
            end
            if (poke && i == 4 && c == 1) begin
               check("ready_poke", {31'd0, ready[d]}, 32'd0);
               valid[d] = 1'b0;
            end
            @(posedge clk); #1;
         end
      end
      check("done_pulse", {29'd0, done[d], ready[d], tx[d]}, 32'd7);
   endtask

   initial begin
      data[0] = '0;
      data[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", {28'd0, tx[0], busy[0], done[0], ready[0]}, 32'b1001);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // basic 0xA5 frame with data change and a rejected mid-frame request
      send(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;
      check("done_width", {31'd0, done[0]}, 32'd0);
      // back-to-back 0x00 then 0xFF with valid held high
      send(0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
      send(0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      // abort during the fourth data bit
      data[0]  = 8'hA5;
      valid[0] = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      repeat (44) @(posedge clk);
      #2;
      check("tx_before_abort", {31'd0, tx[0]}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_outs", {28'd0, tx[0], busy[0], done[0], ready[0]}, 32'b1001);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort_no_done", {30'd0, done[0], tx[0]}, 32'd1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
      // two stop bits
      send(1, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1;
      check("idle_line", {30'd0, tx}, 32'd3);
`ifdef UART_TX_PARITY_EN
      send(0, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
